// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue
//   Burst instruction prefetcher with an integrated first-word-fall-through
//   queue. Fetches BURST_LEN words at a time from the external instruction
//   port, refills whenever the queue has room for a whole burst, stops on a
//   HALT word, and supports redirect (flush + refetch).
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   start, start_addr    one-cycle pulse to begin fetching at start_addr
//   redirect, redirect_addr  flush queue and refetch (highest priority)
//   stop                 stop issuing reads (in-flight read still lands)
//   i_instr              read data, valid one cycle after i_instr_rd_en
//   i_instr_addr, i_instr_rd_en  external read address / strobe
//   o_instr, o_instr_valid, o_instr_ready  FWFT dequeue handshake
//   count, empty, full   registered queue status
//   halt_seen            HALT captured since last start/redirect
//   busy                 fetching, holding, or a read is in flight
module instr_prefetch_queue #(
  parameter int         INSTR_WIDTH = 64,
  parameter int         ADDR_WIDTH  = 16,
  parameter int         DEPTH       = 16,
  parameter int         BURST_LEN   = 4,
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    start_addr,
  input  logic                     redirect,
  input  logic [ADDR_WIDTH-1:0]    redirect_addr,
  input  logic                     stop,
  input  logic [INSTR_WIDTH-1:0]   i_instr,
  output logic [ADDR_WIDTH-1:0]    i_instr_addr,
  output logic                     i_instr_rd_en,
  output logic [INSTR_WIDTH-1:0]   o_instr,
  output logic                     o_instr_valid,
  input  logic                     o_instr_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     halt_seen,
  output logic                     busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [PTR_W-1:0]        burst_q, burst_d;  // BURST_LEN <= DEPTH/2 always fits
  logic                    pending_q, pending_d;
  logic                    halt_q, halt_d;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    empty_q, full_q, busy_q;
  logic [INSTR_WIDTH-1:0]  mem [DEPTH];

  logic rd_issue, push, pop, halt_word, room_ok;

  assign rd_issue  = (state_q == FETCH);
  // pending_q is only set for reads whose return is to be kept, so a
  // discarded return never reaches the queue.
  assign push      = pending_q && !redirect;
  assign pop       = !empty_q && o_instr_ready && !redirect;
  assign halt_word = push && (i_instr[INSTR_WIDTH-1 -: 8] == HALT_OPCODE);
  // Room for a full burst, counting the word still in flight.
  assign room_ok   = ({1'b0, count_q} + (CNT_W+1)'(pending_q) + (CNT_W+1)'(BURST_LEN))
                     <= (CNT_W+1)'(DEPTH);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    burst_d   = burst_q;
    halt_d    = halt_q;
    pending_d = rd_issue && !halt_word && !redirect;
    if (rd_issue) begin
      pc_d    = pc_q + ADDR_WIDTH'(1);
      burst_d = burst_q + PTR_W'(1);
    end
    if (redirect) begin
      state_d = FETCH;
      pc_d    = redirect_addr;
      burst_d = '0;
      halt_d  = 1'b0;
    end else if (halt_word) begin
      state_d = IDLE;
      halt_d  = 1'b1;
    end else if (stop) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          state_d = FETCH;
          pc_d    = start_addr;
          burst_d = '0;
          halt_d  = 1'b0;
        end
        FETCH: if (burst_q == PTR_W'(BURST_LEN - 1)) state_d = HOLD;
        HOLD: if (room_ok) begin
          state_d = FETCH;
          burst_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (redirect)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + CNT_W'(1);
    else if (pop && !push)
      count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      burst_q   <= '0;
      pending_q <= 1'b0;
      halt_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      burst_q   <= burst_d;
      pending_q <= pending_d;
      halt_q    <= halt_d;
      count_q   <= count_d;
      empty_q   <= (count_d == '0);
      full_q    <= (count_d == CNT_W'(DEPTH));
      busy_q    <= (state_d != IDLE) || pending_d;
      if (redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= i_instr;
  end

  assign i_instr_addr  = pc_q;
  assign i_instr_rd_en = rd_issue;
  assign o_instr       = empty_q ? '0 : mem[rd_ptr_q];
  assign o_instr_valid = !empty_q;
  assign count         = count_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign halt_seen     = halt_q;
  assign busy          = busy_q;

endmodule
